// File: rtl/hsid_x_obi_inf_pkg.sv
// OBI bus structs shared by the responder (hsid_x_obi_mem), the bus debug
// monitor and the reader. Address/data are 32 bit, one byte enable per byte.
//   obi_req_t  : req, we, be, addr, wdata   (manager -> responder)
//   obi_resp_t : gnt, rvalid, rdata         (responder -> manager)
package hsid_x_obi_inf_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/hsid_x_obi_reader_pkg.sv
// Types and defaults for the OBI read initiator.
package hsid_x_obi_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } reader_state_e;

  localparam int WORD_BYTES     = 4;
  localparam int DEF_MAX_OUTST  = 2;
  localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/hsid_x_obi_rd_fifo.sv
// Registered 32-bit synchronous FIFO holding read responses until the
// stream consumer takes them.
//   push/wdata : write side (ignored when full)
//   pop/rdata  : read side, rdata is the current head (ignored when empty)
//   full/empty/count : occupancy
module hsid_x_obi_rd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [31:0]                wdata,
  input  logic                       pop,
  output logic [31:0]                rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][31:0] mem;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic                   do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/hsid_x_obi_reader.sv
// OBI read initiator: on start_i reads num_words_i consecutive words from a
// word-aligned base, keeps up to MAX_OUTST reads in flight and streams the
// data out in order on a valid/ready interface.
//   start_i/base_addr_i/num_words_i : transfer command (IDLE only)
//   obi_req/obi_rsp                 : OBI manager port (reads only)
//   data_o/data_valid_o/data_ready_i/data_last_o : output stream
//   busy_o/done_o/proto_err_o       : status
module hsid_x_obi_reader
  import hsid_x_obi_reader_pkg::*;
#(
  parameter int MAX_OUTST  = DEF_MAX_OUTST,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int LEN_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic [31:0]                   base_addr_i,
  input  logic [LEN_W-1:0]              num_words_i,
  output hsid_x_obi_inf_pkg::obi_req_t  obi_req,
  input  hsid_x_obi_inf_pkg::obi_resp_t obi_rsp,
  output logic [31:0]                   data_o,
  output logic                          data_valid_o,
  input  logic                          data_ready_i,
  output logic                          data_last_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          proto_err_o
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  reader_state_e    state_q;
  logic [31:0]      addr_q;
  logic [LEN_W-1:0] remaining_q, num_q, delivered_q;
  logic [OW-1:0]    outst_q;
  logic [3:0]       be_q;
  logic             done_q, proto_err_q;

  logic [CW-1:0]    fifo_count;
  logic             fifo_full, fifo_empty;
  logic [31:0]      fifo_head;
  logic             req, fire, rsp_ok, pop, start_acc, credit_ok, err;

  // Every granted read already owns a FIFO slot, so the FIFO cannot overflow.
  // The sum only shrinks without a grant, so once req rises it stays up
  // until granted.
  assign credit_ok = !fifo_full
                  && ((int'(outst_q) + int'(fifo_count)) < FIFO_DEPTH)
                  && (int'(outst_q) < MAX_OUTST);
  assign req       = (state_q == ISSUE) && (remaining_q != '0) && credit_ok;
  assign fire      = req && obi_rsp.gnt;
  assign rsp_ok    = obi_rsp.rvalid && (outst_q != '0);
  assign err       = (obi_rsp.rvalid && (outst_q == '0)) || (obi_rsp.gnt && !req);
  assign pop       = data_valid_o && data_ready_i;
  assign start_acc = start_i && (state_q == IDLE);

  hsid_x_obi_rd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_ok),
    .wdata (obi_rsp.rdata),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign data_valid_o = !fifo_empty;
  assign data_o       = fifo_empty ? '0 : fifo_head;
  assign data_last_o  = data_valid_o && (delivered_q == num_q - LEN_W'(1));
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign proto_err_o  = proto_err_q;

  // be is a register only so the request port reads all-zero under reset.
  always_comb begin
    obi_req      = '0;
    obi_req.req  = req;
    obi_req.be   = be_q;
    obi_req.addr = addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      num_q       <= '0;
      delivered_q <= '0;
      outst_q     <= '0;
      be_q        <= '0;
      done_q      <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      be_q        <= 4'hF;
      done_q      <= 1'b0;
      proto_err_q <= (proto_err_q && !start_acc) || err;
      if (pop) delivered_q <= delivered_q + LEN_W'(1);

      case ({fire, rsp_ok})
        2'b10:   outst_q <= outst_q + OW'(1);
        2'b01:   outst_q <= outst_q - OW'(1);
        default: ;
      endcase

      case (state_q)
        IDLE: if (start_i) begin
          addr_q      <= base_addr_i & ~32'h3;
          remaining_q <= num_words_i;
          num_q       <= num_words_i;
          delivered_q <= '0;
          state_q     <= (num_words_i == '0) ? DONE : ISSUE;
        end
        ISSUE: if (fire) begin
          addr_q      <= addr_q + 32'(WORD_BYTES);
          remaining_q <= remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_q <= DRAIN;
        end
        DRAIN: if ((outst_q == '0) && fifo_empty) state_q <= DONE;
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hsid_x_obi_reader.sv
// Bench for hsid_x_obi_reader: a queue-based OBI responder with a fixed
// memory pattern, a random-ready stream consumer, and per-scenario tasks.
module tb_hsid_x_obi_reader;
  import hsid_x_obi_inf_pkg::*;

  localparam int MAX_OUTST  = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int LEN_W      = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start_i = 1'b0;
  logic [31:0]      base_addr_i = '0;
  logic [LEN_W-1:0] num_words_i = '0;
  obi_req_t         obi_req;
  obi_resp_t        obi_rsp = '0;
  logic [31:0]      data_o;
  logic             data_valid_o, data_ready_i = 1'b0, data_last_o;
  logic             busy_o, done_o, proto_err_o;

  hsid_x_obi_reader #(.MAX_OUTST(MAX_OUTST), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
    .num_words_i(num_words_i), .obi_req(obi_req), .obi_rsp(obi_rsp),
    .data_o(data_o), .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
    .data_last_o(data_last_o), .busy_o(busy_o), .done_o(done_o), .proto_err_o(proto_err_o)
  );

  int cmp = 0, errs = 0, cyc = 0;

  // Knobs
  int lat = 1, gnt_pct = 100, ready_pct = 100, gnt_block = 0, ready_block = 0;
  bit start_req = 0, spur_req = 0;

  // Observations
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       pend[$];
  logic [31:0] addr_log[$];
  logic [31:0] rx_data[$];
  logic        rx_last[$];
  int          rx_cyc[$];
  int done_cnt, done_cyc, start_cyc, stab_viol, max_out, req_cnt, valid_cnt;
  logic busy_after_start;

  // What was driven / seen at the previous negedge
  logic        p_req = 0, p_gnt = 0, p_rv = 0, p_spur = 0, p_valid = 0, p_ready = 0, p_last = 0;
  logic [31:0] p_addr = '0, p_data = '0, p_rdata = '0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction
  function automatic logic [31:0] exp_addr(logic [31:0] base, int i);
    return {base[31:2], 2'b00} + 32'(i) * 32'd4;
  endfunction
  function automatic logic [31:0] exp_word(logic [31:0] base, int i);
    return mem_word(exp_addr(base, i));
  endfunction

  // One cycle: account what happened at the last posedge, then drive the next.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (p_gnt && p_req) begin
      pend.push_back('{p_addr, cyc + lat - 1});
      addr_log.push_back(p_addr);
    end
    if (p_rv && !p_spur) void'(pend.pop_front());
    if (p_valid && p_ready) begin
      rx_data.push_back(p_data); rx_last.push_back(p_last); rx_cyc.push_back(cyc);
    end
    if (p_req && !p_gnt && (!obi_req.req || obi_req.addr != p_addr)) stab_viol++;
    if (pend.size() > max_out) max_out = pend.size();
    if (done_o) begin done_cnt++; done_cyc = cyc; end
    if (obi_req.req) req_cnt++;
    if (data_valid_o) valid_cnt++;

    start_i = start_req; start_req = 0;
    p_req = obi_req.req; p_addr = obi_req.addr;
    if (p_req && gnt_block > 0) begin p_gnt = 0; gnt_block--; end
    else p_gnt = p_req && ($urandom_range(99) < gnt_pct);
    p_spur = 0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      p_rv = 1; p_rdata = mem_word(pend[0].addr);
    end else if (spur_req) begin
      p_rv = 1; p_spur = 1; p_rdata = 32'hDEAD_BEEF; spur_req = 0;
    end else begin
      p_rv = 0; p_rdata = $urandom;
    end
    obi_rsp.gnt = p_gnt; obi_rsp.rvalid = p_rv; obi_rsp.rdata = p_rdata;
    if (ready_block > 0) begin p_ready = 0; ready_block--; end
    else p_ready = ($urandom_range(99) < ready_pct);
    data_ready_i = p_ready;
    p_valid = data_valid_o; p_data = data_o; p_last = data_last_o;
  endtask

  task automatic run_xfer(input logic [31:0] base, input int n, input int restart_at);
    bit fin = 0;
    addr_log.delete(); rx_data.delete(); rx_last.delete(); rx_cyc.delete();
    done_cnt = 0; done_cyc = -1; stab_viol = 0; max_out = 0; req_cnt = 0; valid_cnt = 0;
    base_addr_i = base; num_words_i = LEN_W'(n); start_req = 1;
    step(); start_cyc = cyc;
    for (int i = 0; i < 3000 && !fin; i++) begin
      if (i == restart_at) begin base_addr_i = 32'h9000; num_words_i = 3; start_req = 1; end
      step();
      if (i == 0) busy_after_start = busy_o;
      if (done_cnt > 0) fin = 1;
    end
    cmp++;
    if (!fin) begin errs++; $display("FAIL xfer_timeout: base %h n %0d no done_o", base, n); end
    repeat (3) step();
  endtask

  task automatic test_reset();
    #2;
    cmp++; if (obi_req !== '0) begin errs++; $display("FAIL reset_req: got %h want 0", obi_req); end
    cmp++; if ({data_valid_o, data_last_o, busy_o, done_o, proto_err_o} !== 5'b0) begin
      errs++; $display("FAIL reset_flags: got %b want 00000", {data_valid_o, data_last_o, busy_o, done_o, proto_err_o});
    end
    @(negedge clk); rst_n = 1;
    step(); step();
    cmp++; if (obi_req.be !== 4'hF || obi_req.we !== 1'b0 || obi_req.req !== 1'b0) begin
      errs++; $display("FAIL idle_req: be %h we %b req %b want F/0/0", obi_req.be, obi_req.we, obi_req.req);
    end
  endtask

  task automatic test_basic();
    lat = 1; gnt_pct = 100; ready_pct = 100;
    run_xfer(32'h100, 4, -1);
    cmp++; if (addr_log.size() != 4) begin errs++; $display("FAIL basic_ngnt: got %0d want 4", addr_log.size()); end
    for (int i = 0; i < addr_log.size() && i < 4; i++) begin
      cmp++; if (addr_log[i] !== exp_addr(32'h100, i)) begin
        errs++; $display("FAIL basic_addr[%0d]: got %h want %h", i, addr_log[i], exp_addr(32'h100, i)); end
    end
    cmp++; if (rx_data.size() != 4) begin errs++; $display("FAIL basic_nrx: got %0d want 4", rx_data.size()); end
    for (int i = 0; i < rx_data.size() && i < 4; i++) begin
      cmp++; if (rx_data[i] !== exp_word(32'h100, i) || rx_last[i] !== (i == 3)) begin
        errs++; $display("FAIL basic_data[%0d]: got %h/%b want %h/%b", i, rx_data[i], rx_last[i], exp_word(32'h100, i), i == 3); end
    end
    for (int i = 1; i < rx_cyc.size(); i++) begin
      cmp++; if (rx_cyc[i] - rx_cyc[i-1] != 1) begin
        errs++; $display("FAIL basic_rate[%0d]: gap %0d want 1", i, rx_cyc[i] - rx_cyc[i-1]); end
    end
    cmp++; if (done_cnt != 1) begin errs++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
    cmp++; if (busy_after_start !== 1'b1) begin errs++; $display("FAIL basic_busy: got %b want 1", busy_after_start); end
    cmp++; if (proto_err_o !== 1'b0) begin errs++; $display("FAIL basic_perr: got %b want 0", proto_err_o); end
  endtask

  task automatic test_zero_len();
    run_xfer(32'h200, 0, -1);
    cmp++; if (req_cnt != 0) begin errs++; $display("FAIL zero_req: got %0d req cycles want 0", req_cnt); end
    cmp++; if (done_cyc - start_cyc != 2) begin errs++; $display("FAIL zero_done_lat: got %0d want 2", done_cyc - start_cyc); end
    cmp++; if (valid_cnt != 0) begin errs++; $display("FAIL zero_valid: got %0d want 0", valid_cnt); end
    cmp++; if (done_cnt != 1) begin errs++; $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    bit fin = 0;
    lat = 1; gnt_pct = 100; ready_pct = 100; ready_block = 20;
    addr_log.delete(); rx_data.delete(); rx_last.delete(); rx_cyc.delete(); done_cnt = 0;
    base_addr_i = 32'h3000; num_words_i = 8; start_req = 1;
    repeat (18) step();
    cmp++; if (addr_log.size() != FIFO_DEPTH) begin
      errs++; $display("FAIL bp_grants: got %0d want %0d", addr_log.size(), FIFO_DEPTH); end
    for (int i = 0; i < 3000 && !fin; i++) begin step(); if (done_cnt > 0) fin = 1; end
    cmp++; if (!fin) begin errs++; $display("FAIL bp_timeout: no done_o"); end
    cmp++; if (rx_data.size() != 8) begin errs++; $display("FAIL bp_nrx: got %0d want 8", rx_data.size()); end
    for (int i = 0; i < rx_data.size() && i < 8; i++) begin
      cmp++; if (rx_data[i] !== exp_word(32'h3000, i) || rx_last[i] !== (i == 7)) begin
        errs++; $display("FAIL bp_data[%0d]: got %h/%b want %h/%b", i, rx_data[i], rx_last[i], exp_word(32'h3000, i), i == 7); end
    end
  endtask

  task automatic test_gnt_stall();
    lat = 3; gnt_pct = 100; ready_pct = 100; gnt_block = 5;
    run_xfer(32'h4000, 6, -1);
    cmp++; if (stab_viol != 0) begin errs++; $display("FAIL stall_stable: got %0d violations want 0", stab_viol); end
    cmp++; if (max_out != MAX_OUTST) begin errs++; $display("FAIL stall_outst: got max %0d want %0d", max_out, MAX_OUTST); end
    cmp++; if (rx_data.size() != 6) begin errs++; $display("FAIL stall_nrx: got %0d want 6", rx_data.size()); end
    for (int i = 0; i < rx_data.size() && i < 6; i++) begin
      cmp++; if (rx_data[i] !== exp_word(32'h4000, i) || addr_log[i] !== exp_addr(32'h4000, i)) begin
        errs++; $display("FAIL stall_data[%0d]: got %h@%h want %h@%h", i, rx_data[i], addr_log[i], exp_word(32'h4000, i), exp_addr(32'h4000, i)); end
    end
  endtask

  task automatic test_addr_wrap();
    lat = 1; gnt_pct = 100; ready_pct = 100;
    run_xfer(32'hFFFF_FFFE, 2, -1);
    cmp++; if (addr_log.size() != 2) begin errs++; $display("FAIL wrap_ngnt: got %0d want 2", addr_log.size()); end
    else begin
      cmp++; if (addr_log[0] !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_addr0: got %h want FFFFFFFC", addr_log[0]); end
      cmp++; if (addr_log[1] !== 32'h0000_0000) begin errs++; $display("FAIL wrap_addr1: got %h want 00000000", addr_log[1]); end
    end
    cmp++; if (proto_err_o !== 1'b0) begin errs++; $display("FAIL wrap_perr: got %b want 0", proto_err_o); end
    cmp++; if (rx_data.size() != 2 || rx_data[1] !== mem_word(32'h0) || rx_last[1] !== 1'b1) begin
      errs++; $display("FAIL wrap_data: got n=%0d last word %h want n=2 %h", rx_data.size(), rx_data[rx_data.size()-1], mem_word(32'h0)); end
  endtask

  task automatic test_busy_start();
    lat = 1; gnt_pct = 100; ready_pct = 100;
    run_xfer(32'h2000, 5, 3);
    cmp++; if (done_cnt != 1) begin errs++; $display("FAIL busy_start_done: got %0d want 1", done_cnt); end
    cmp++; if (addr_log.size() != 5 || rx_data.size() != 5) begin
      errs++; $display("FAIL busy_start_n: got %0d grants %0d words want 5/5", addr_log.size(), rx_data.size()); end
    for (int i = 0; i < rx_data.size() && i < 5; i++) begin
      cmp++; if (rx_data[i] !== exp_word(32'h2000, i) || rx_last[i] !== (i == 4)) begin
        errs++; $display("FAIL busy_start_data[%0d]: got %h/%b want %h/%b", i, rx_data[i], rx_last[i], exp_word(32'h2000, i), i == 4); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      logic [31:0] base = $urandom;
      int n = $urandom_range(1, 12);
      lat = $urandom_range(1, 4); gnt_pct = $urandom_range(30, 100); ready_pct = $urandom_range(30, 100);
      run_xfer(base, n, -1);
      cmp++; if (rx_data.size() != n || addr_log.size() != n) begin
        errs++; $display("FAIL rand%0d_n: got %0d words %0d grants want %0d", k, rx_data.size(), addr_log.size(), n); end
      for (int i = 0; i < rx_data.size() && i < n; i++) begin
        cmp++; if (rx_data[i] !== exp_word(base, i) || rx_last[i] !== (i == n - 1)) begin
          errs++; $display("FAIL rand%0d_data[%0d]: got %h/%b want %h/%b", k, i, rx_data[i], rx_last[i], exp_word(base, i), i == n - 1); end
      end
      cmp++; if (stab_viol != 0 || max_out > MAX_OUTST) begin
        errs++; $display("FAIL rand%0d_proto: stab %0d maxout %0d want 0/<=%0d", k, stab_viol, max_out, MAX_OUTST); end
    end
  endtask

  task automatic test_error_reset();
    lat = 1; gnt_pct = 100; ready_pct = 100;
    spur_req = 1; step(); step();
    cmp++; if (proto_err_o !== 1'b1) begin errs++; $display("FAIL err_set: got %b want 1", proto_err_o); end
    cmp++; if (data_valid_o !== 1'b0) begin errs++; $display("FAIL err_nopush: valid %b want 0", data_valid_o); end
    base_addr_i = 32'h400; num_words_i = 8; start_req = 1; ready_block = 100;
    step(); step();
    cmp++; if (proto_err_o !== 1'b0) begin errs++; $display("FAIL err_clear: got %b want 0", proto_err_o); end
    repeat (4) step();
    cmp++; if (busy_o !== 1'b1 || data_valid_o !== 1'b1) begin
      errs++; $display("FAIL mid_state: busy %b valid %b want 1/1", busy_o, data_valid_o); end
    rst_n = 0; #1;
    cmp++; if (obi_req !== '0 || data_o !== 32'h0) begin
      errs++; $display("FAIL rst_req: req %h data %h want 0/0", obi_req, data_o); end
    cmp++; if ({data_valid_o, data_last_o, busy_o, done_o, proto_err_o} !== 5'b0) begin
      errs++; $display("FAIL rst_flags: got %b want 00000", {data_valid_o, data_last_o, busy_o, done_o, proto_err_o}); end
    obi_rsp = '0; pend.delete(); ready_block = 0; start_req = 0; start_i = 0; spur_req = 0;
    p_req = 0; p_gnt = 0; p_rv = 0; p_spur = 0; p_valid = 0; p_ready = 0;
    @(negedge clk); rst_n = 1;
    run_xfer(32'h500, 3, -1);
    cmp++; if (rx_data.size() != 3 || rx_data[0] !== exp_word(32'h500, 0) || rx_data[2] !== exp_word(32'h500, 2)) begin
      errs++; $display("FAIL rst_recover: got n=%0d first %h want 3 %h", rx_data.size(), rx_data[0], exp_word(32'h500, 0)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_gnt_stall();
    test_addr_wrap();
    test_busy_start();
    test_random();
    test_error_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule

// File: doc/hsid_x_obi_reader.md
Name: hsid_x_obi_reader

Overview:
OBI read initiator (manager) that drives the same obi_req_t / obi_resp_t pair that the bus debug monitor observes, from the opposite end: it issues the requests and consumes the responses. On a start pulse it reads num_words consecutive 32-bit words from a word-aligned base address. It keeps up to MAX_OUTST reads in flight and delivers the read data in order on a valid/ready stream. It sits between an OBI memory (hsid_x_obi_mem) and a streaming consumer, such as the HSI pixel datapath.

Parameters:
MAX_OUTST, 2, maximum granted-but-unanswered reads; 1..4.
FIFO_DEPTH, 4, response buffer depth in words; power of two, ≥ MAX_OUTST.
LEN_W, 16, width of num_words_i.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset; asynchronous assert, active-low
start_i  input  1  single-cycle start pulse; ignored while busy_o=1
base_addr_i  input  32  first word address; bits [1:0] ignored (forced 0)
num_words_i  input  LEN_W  number of words to read; sampled on start
obi_req  output  hsid_x_obi_inf_pkg::obi_req_t  req/we/be/addr/wdata to responder
obi_rsp  input  hsid_x_obi_inf_pkg::obi_resp_t  gnt/rvalid/rdata from responder
data_o  output  32  stream data
data_valid_o  output  1  stream valid
data_ready_i  input  1  stream ready
data_last_o  output  1  marks the final word of the transfer (qualified by valid)
busy_o  output  1  high from the cycle after an accepted start until done_o
done_o  output  1  one-cycle pulse after the last word is accepted downstream
proto_err_o  output  1  sticky flag; cleared only by reset or by an accepted start

Behaviour:
- Reset values: obi_req is all-zero (req=0, we=0, be=0, addr=0, wdata=0). data_valid_o, data_last_o, busy_o, done_o and proto_err_o are 0. FIFO is empty, counters are 0, FSM is in IDLE.
- Constant request fields: we=0 and be=4'hF always; wdata=0.
- FSM states and transitions:
  - IDLE: on start_i, latch addr = {base_addr_i[31:2], 2'b00} and remaining = num_words_i. Go to ISSUE, or to DONE if num_words_i = 0.
  - ISSUE: drive req while remaining>0 and (outstanding + fifo_count) < FIFO_DEPTH and outstanding < MAX_OUTST.
    - On req&gnt: addr += 4 (32-bit wrap, no error); remaining -= 1; outstanding += 1.
    - When remaining = 0 after a grant, go to DRAIN.
  - DRAIN: wait until outstanding = 0 and the FIFO is empty after the last pop, then go to DONE.
  - DONE: assert done_o for one cycle, deassert busy_o, return to IDLE.
- OBI address phase: once req=1, req and addr stay stable until gnt. req is never withdrawn without a grant, even if the credit check would now fail.
- OBI response phase: rvalid arrives ≥1 cycle after the corresponding gnt, in order.
  - Each rvalid pushes rdata into the FIFO and decrements outstanding.
  - The credit check guarantees the FIFO never overflows.
- Simultaneous events:
  - gnt and rvalid in the same cycle: outstanding is unchanged.
  - FIFO push and pop in the same cycle: fifo_count is unchanged.
- Stream:
  - data_valid_o = FIFO not empty; data_o = FIFO head.
  - A pop happens on valid&ready.
  - data_last_o = 1 when the head is the final word: delivered count = num_words-1.
  - Zero-cycle bypass is not required. Minimum latency from rvalid to data_valid_o is 1 cycle (registered FIFO).
- Throughput: with gnt tied high, 1-cycle rvalid and ready=1, one word per cycle is sustained.
- Protocol error: rvalid while outstanding = 0, or gnt while req = 0.
  - Sets proto_err_o.
  - A spurious rvalid is dropped (no FIFO push).
- start_i while busy_o=1: ignored, with no side effect.
- Reset mid-transfer: all state is cleared asynchronously and the in-flight responses are lost. The responder must also be reset.

Decomposition:
- hsid_x_obi_reader_pkg:
  - state enum reader_state_e {IDLE, ISSUE, DRAIN, DONE};
  - localparam WORD_BYTES = 4;
  - default MAX_OUTST and FIFO_DEPTH.
- OBI struct types come from hsid_x_obi_inf_pkg, unchanged.
- One sub-module: hsid_x_obi_rd_fifo.
  - Synchronous FIFO, 32-bit, parameter DEPTH.
  - Ports: push, pop, full, empty, count.
  - Same clk/rst_n.

Test Plan:
- Basic read: start with base=0x100, num=4; gnt=1, rvalid 1 cycle later, ready=1.
  - addr sequence is 0x100, 0x104, 0x108, 0x10C.
  - Data arrives in order, with data_last_o on the 4th word.
  - done_o pulses exactly once; busy_o is high for 4+latency cycles.
- Zero length: num=0.
  - No req is ever asserted.
  - done_o pulses 2 cycles after start; no data_valid_o.
- Backpressure: num=8, ready held 0 for 20 cycles.
  - req stops after exactly FIFO_DEPTH=4 grants.
  - No overflow; all 8 words are delivered in order once ready=1.
- Grant stall: gnt low for 5 cycles while req=1.
  - addr and req are held stable throughout.
  - outstanding never exceeds MAX_OUTST=2 when rvalid lags by 3 cycles.
- Address wrap and misaligned base: base=0xFFFF_FFFE, num=2.
  - addr sequence is 0xFFFF_FFFC then 0x0000_0000.
  - proto_err_o stays 0.
- Error and reset:
  - Inject rvalid while idle: proto_err_o goes to 1 and the FIFO stays empty.
  - Next start clears proto_err_o.
  - Assert rst_n=0 mid-transfer: all outputs return to 0 immediately.
